dpram_burst_reader: RTL and testbench
=====================================

# dpram_burst_reader

Read-side streaming engine for one port of the shared dual-port RAM. Accepts a burst command (start address, word count), issues one read per cycle on a RAM port, absorbs the RAM's one-cycle registered read latency, and delivers the words on a valid/ready stream with full backpressure support. Used by the minimal core to dump memory regions (stack/dictionary images) to downstream consumers without stalling the other RAM port.

## Interface
- `DATA`, 8, RAM word width
- `ADDR`, 10, RAM address width; RAM depth is 2**ADDR
- `LEN`, ADDR+1, width of `cmd_len`; must hold 2**ADDR

- `clk`  in  1  single clock; RAM port must share it
- `reset`  in  1  synchronous, active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_addr`  in  ADDR  first word address
- `cmd_len`  in  LEN  word count; 0 = no-op
- `cmd_desc`  in  1  descending order (present only with `DPRAM_RD_DESC_EN`)
- `mem_wr`  out  1  RAM port write enable; constant 0
- `mem_addr`  out  ADDR  RAM port address, registered
- `mem_din`  out  DATA  RAM port write data; constant 0
- `mem_dout`  in  DATA  RAM port read data, valid the cycle after the address is sampled
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  consumer ready
- `out_data`  out  DATA  stream word
- `out_last`  out  1  qualifies final word of burst
- `busy`  out  1  high in RUN or DRAIN

## Operation
- States: IDLE, RUN, DRAIN. `cmd_ready` = (state == IDLE).
- IDLE: on accept with `cmd_len` != 0 -> `mem_addr <= cmd_addr`, `remaining <= cmd_len`, RUN. With `cmd_len` == 0: accepted, stays IDLE, no reads, no output.
- RUN: a read is *issued* in any cycle where `entries + inflight - pop < 2` (`entries` = 2-entry output FIFO occupancy, `inflight` = read issued last cycle, `pop` = `out_valid && out_ready`). On issue: `mem_addr` steps by 1 modulo 2**ADDR, `remaining` decrements, `inflight <= 1`; else `mem_addr` holds, `inflight <= 0`. Issue with `remaining` == 1 -> DRAIN.
- Every cycle with `inflight` = 1, `mem_dout` is pushed to the FIFO, tagged `last` if it is the burst's final word. Credit rule guarantees the FIFO never overflows.
- DRAIN: -> IDLE when `entries` == 0 and `inflight` == 0.
- `out_data`/`out_last` come from the FIFO head; `out_valid` = `entries` != 0. While `out_valid && !out_ready`, `out_data` and `out_last` stay stable.
- Address wraps: 2**ADDR-1 -> 0. `cmd_len` == 2**ADDR reads every location exactly once.

## Timing
- Reset values: `cmd_ready`=1, `mem_addr`=0, `mem_wr`=0, `mem_din`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0; FIFO empty, `inflight`=0, state IDLE.
- Latency: accept at cycle T -> first issue T+1 -> `mem_dout` valid T+2 -> `out_valid` first high in T+3.
- Throughput: one word per cycle with `out_ready` held high; zero bubbles between words.
- Backpressure: at most 2 words buffered/in flight; `mem_addr` leads the last delivered word by at most 2.
- Reset mid-burst: all state cleared at that edge; in-flight and buffered words discarded; `out_valid` low the following cycle; next command behaves as after power-up.
- `cmd_valid` in RUN/DRAIN is ignored (not accepted) until IDLE.

## Configuration
- `DPRAM_RD_DESC_EN` defined: `cmd_desc` port exists, latched on accept; when 1, `mem_addr` steps by -1 modulo 2**ADDR (0 -> 2**ADDR-1), used for stack-pop order dumps.
- Not defined: `cmd_desc` absent; addresses always ascend.

## Test plan
- ADDR=4, mem[i]=0x10+i, cmd addr 3 len 4, `out_ready`=1 -> 0x13,0x14,0x15,0x16 on consecutive cycles from T+3, `out_last` only on 0x16, `cmd_ready` high again the cycle after 0x16 is taken.
- Wrap: addr 14 len 4 -> 0x1E,0x1F,0x10,0x11.
- Backpressure: addr 0 len 8, `out_ready` low 5 cycles after first word then toggling -> all 8 words in order, no loss/duplication, `out_data` stable while stalled, `mem_addr` never more than 2 past the delivered word.
- Len 0: accepted, `cmd_ready` stays 1, `busy` stays 0, no `out_valid`.
- Reset after 2 words of len-8 burst -> `out_valid` 0 next cycle, all outputs at reset values; new cmd addr 5 len 2 -> 0x15,0x16 with T+3 latency.
- With `DPRAM_RD_DESC_EN`: addr 1 len 3 desc=1 -> 0x11,0x10,0x1F, `out_last` on 0x1F.

Source files
------------

// File: rtl/dpram_burst_reader.sv
// Burst read engine for one dual-port RAM port: command in, valid/ready word stream out.
// Define DPRAM_RD_DESC_EN to add the cmd_desc port for descending-address bursts.
module dpram_burst_reader #(
  parameter int DATA = 8,
  parameter int ADDR = 10,
  parameter int LEN  = ADDR + 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [ADDR-1:0] i_cmd_addr,
  input  logic [LEN-1:0]  i_cmd_len,
`ifdef DPRAM_RD_DESC_EN
  input  logic            i_cmd_desc,
`endif
  output logic            o_mem_wr,
  output logic [ADDR-1:0] o_mem_addr,
  output logic [DATA-1:0] o_mem_din,
  input  logic [DATA-1:0] i_mem_dout,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [DATA-1:0] o_out_data,
  output logic            o_out_last,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR-1:0] r_addr;
  logic [LEN-1:0]  r_rem;
  logic            r_inflight;
  logic            r_inflight_last;
  logic [1:0]      r_cnt;
  logic            r_wp;
  logic            r_rp;
  logic [DATA-1:0] r_fifo_data [2];
  logic            r_fifo_last [2];

  logic            w_pop;
  logic            w_push;
  logic            w_start;
  logic            w_issue;
  logic            w_rem_last;
  logic [2:0]      w_occ;
  logic [1:0]      w_cnt_nxt;
  logic [ADDR-1:0] w_addr_step;

`ifdef DPRAM_RD_DESC_EN
  logic r_desc;

  assign w_addr_step = r_desc ? r_addr - ADDR'(1)
                              : r_addr + ADDR'(1);
`else
  assign w_addr_step = r_addr + ADDR'(1);
`endif

  assign w_pop      = (r_cnt != 2'd0) && i_out_ready;
  assign w_push     = r_inflight;
  assign w_start    = i_cmd_valid && (r_state == S_IDLE)
                   && (i_cmd_len != '0);
  assign w_rem_last = (r_rem == LEN'(1));

  // Credit: buffered plus in-flight words, less this cycle's pop, stays below 2.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign w_issue = (r_state == S_RUN)
                && (w_occ < (3'd2 + {2'b00, w_pop}));

  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_issue && w_rem_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((w_cnt_nxt == 2'd0) && !r_inflight)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr          <= '0;
      r_rem           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_cnt           <= 2'd0;
      r_wp            <= 1'b0;
      r_rp            <= 1'b0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last[0]  <= 1'b0;
      r_fifo_last[1]  <= 1'b0;
`ifdef DPRAM_RD_DESC_EN
      r_desc          <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_addr <= i_cmd_addr;
        r_rem  <= i_cmd_len;
`ifdef DPRAM_RD_DESC_EN
        r_desc <= i_cmd_desc;
`endif
      end else if (w_issue) begin
        r_addr <= w_addr_step;
        r_rem  <= r_rem - LEN'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_rem_last;
      if (w_push) begin
        r_fifo_data[r_wp] <= i_mem_dout;
        r_fifo_last[r_wp] <= r_inflight_last;
        r_wp              <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_mem_wr    = 1'b0;
  assign o_mem_din   = '0;
  assign o_mem_addr  = r_addr;
  assign o_out_valid = (r_cnt != 2'd0);
  assign o_out_data  = r_fifo_data[r_rp];
  assign o_out_last  = r_fifo_last[r_rp];

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Bench for dpram_burst_reader: directed table, reset/len-0 sequences, random bursts.
// Reference: expected word list built from the RAM image and start/len/direction.
module tb_dpram_burst_reader;
  localparam int DATA  = 8;
  localparam int ADDR  = 4;
  localparam int LEN   = 5;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [ADDR-1:0] cmd_addr;
  logic [LEN-1:0]  cmd_len;
  logic            cmd_desc;
  logic            mem_wr;
  logic [ADDR-1:0] mem_addr;
  logic [DATA-1:0] mem_din;
  logic [DATA-1:0] mem_dout;
  logic            out_valid;
  logic            out_ready;
  logic [DATA-1:0] out_data;
  logic            out_last;
  logic            busy;

  logic [DATA-1:0] mem [DEPTH];

  int vectors     = 0;
  int miscompares = 0;

  dpram_burst_reader #(
    .DATA(DATA),
    .ADDR(ADDR),
    .LEN (LEN)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_addr (cmd_addr),
    .i_cmd_len  (cmd_len),
`ifdef DPRAM_RD_DESC_EN
    .i_cmd_desc (cmd_desc),
`endif
    .o_mem_wr   (mem_wr),
    .o_mem_addr (mem_addr),
    .o_mem_din  (mem_din),
    .i_mem_dout (mem_dout),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_data (out_data),
    .o_out_last (out_last),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read
  always @(posedge clk) mem_dout <= mem[mem_addr];

  typedef struct {
    logic [3:0] addr;
    logic [4:0] len;
    logic       desc;
    int         mode;
    logic [7:0] f;
    logic [7:0] l;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
  endtask

  // mode 0: ready always high, 1: random ready and cmd_valid held,
  // 2: 5-cycle stall after first word then toggling
  task automatic run_cmd(input logic [3:0] a, input logic [4:0] n,
                         input logic d, input int mode,
                         output logic [7:0] f_w, output logic [7:0] l_w);
    logic [7:0] exp_q[$];
    logic [3:0] ai;
    logic [3:0] off;
    logic [3:0] lead;
    int k = 0;
    int cyc = 0;
    int first_c = -1;
    int stall = 0;
    bit done = 0;
    bit pv = 0;
    bit pr = 0;
    logic [7:0] pd = 0;
    logic pl = 0;
    f_w = 8'h00;
    l_w = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      ai = d ? a - 4'(i) : a + 4'(i);
      exp_q.push_back(mem[ai]);
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    cmd_desc  = d;
    out_ready = (mode == 0);
    step();
    cmd_valid = (mode == 1) && (n != 0);
    cmd_addr  = ~a;
    cmd_len   = 5'd3;
    if (n == 0) begin
      for (int i = 0; i < 4; i++) begin
        check("len0_busy", busy, 0);
        check("len0_ready", cmd_ready, 1);
        check("len0_valid", out_valid, 0);
        step();
      end
      return;
    end
    while (!done) begin
      cyc++;
      if (cyc > 400) begin
        check("timeout_words", k, n);
        break;
      end
      if (pv && !pr) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, pd);
        check("stall_last", out_last, pl);
      end
      if (busy) begin
        off  = d ? a - mem_addr : mem_addr - a;
        lead = off - 4'(k);
        check("addr_lead_le2", {31'b0, lead <= 4'd2}, 1);
      end
      if (out_valid) begin
        if (first_c < 0) begin
          first_c = cyc;
          f_w = out_data;
          if (mode == 0) check("latency", cyc, 3);
        end
        if (k < int'(n)) begin
          check("data", out_data, exp_q[k]);
          check("last", out_last, (k == int'(n) - 1));
        end else begin
          check("extra_word", out_valid, 0);
        end
      end else if (mode == 0 && first_c >= 0) begin
        check("bubble", out_valid, 1);
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (k == 0) out_ready = 1'b1;
          else if (stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else out_ready = ~out_ready;
        end
      endcase
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pl = out_last;
      if (out_valid && out_ready) begin
        if (k == int'(n) - 1) begin
          l_w  = out_data;
          done = 1;
        end
        k++;
      end
      step();
    end
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    check("ready_after_last", cmd_ready, 1);
    check("busy_after_last", busy, 0);
    check("word_count", k, n);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [7:0] fw;
    logic [7:0] lw;
    int k;
    int cyc;

    v = '{4'd3,  5'd4,  1'b0, 0, 8'h13, 8'h16}; tbl.push_back(v);
    v = '{4'd14, 5'd4,  1'b0, 0, 8'h1E, 8'h11}; tbl.push_back(v);
    v = '{4'd0,  5'd8,  1'b0, 2, 8'h10, 8'h17}; tbl.push_back(v);
    v = '{4'd15, 5'd1,  1'b0, 0, 8'h1F, 8'h1F}; tbl.push_back(v);
    v = '{4'd0,  5'd16, 1'b0, 1, 8'h10, 8'h1F}; tbl.push_back(v);
    v = '{4'd9,  5'd16, 1'b0, 0, 8'h19, 8'h18}; tbl.push_back(v);
`ifdef DPRAM_RD_DESC_EN
    v = '{4'd1,  5'd3,  1'b1, 0, 8'h11, 8'h1F}; tbl.push_back(v);
    v = '{4'd2,  5'd16, 1'b1, 2, 8'h12, 8'h13}; tbl.push_back(v);
`endif

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h10 + 8'(i);

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_desc  = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check_reset_vals();

    foreach (tbl[i]) begin
      run_cmd(tbl[i].addr, tbl[i].len, tbl[i].desc, tbl[i].mode, fw, lw);
      check("tbl_first", fw, tbl[i].f);
      check("tbl_last", lw, tbl[i].l);
      step();
    end

    run_cmd(4'd7, 5'd0, 1'b0, 0, fw, lw);

    // Reset two words into an 8-word burst
    cmd_valid = 1'b1;
    cmd_addr  = 4'd0;
    cmd_len   = 5'd8;
    cmd_desc  = 1'b0;
    out_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < 2 && cyc < 20) begin
      if (out_valid) k++;
      cyc++;
      step();
    end
    check("pre_reset_words", k, 2);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 1'b0;
    check_reset_vals();
    step();
    check("post_reset_valid", out_valid, 0);
    check("post_reset_busy", busy, 0);
    run_cmd(4'd5, 5'd2, 1'b0, 0, fw, lw);
    check("post_reset_first", fw, 8'h15);
    check("post_reset_last", lw, 8'h16);

    for (int t = 0; t < 30; t++) begin
      logic dd;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
`ifdef DPRAM_RD_DESC_EN
      dd = 1'($urandom_range(0, 1));
`else
      dd = 1'b0;
`endif
      run_cmd(4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)),
              dd, int'($urandom_range(0, 2)), fw, lw);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
